// File: rtl/yin_feed_ctrl.sv
// Sample feeder for the YIN pitch core: buffers incoming audio, issues samples
// at a guaranteed minimum spacing, and holds lag results for a downstream consumer.
module yin_feed_ctrl #(
  parameter int WIDTH       = 16,
  parameter int WINDOW_SIZE = 2048,
  parameter int TAUMAX      = 2048,
  parameter int SAMPLE_GAP  = 1040,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic                      flag_clr_in,
  input  logic [WIDTH-1:0]          sample_in,
  input  logic                      sample_valid_in,
  output logic [WIDTH-1:0]          core_sample_out,
  output logic                      core_valid_out,
  input  logic                      core_result_valid_in,
  input  logic [$clog2(TAUMAX)-1:0] core_taumin_in,
  output logic [$clog2(TAUMAX)-1:0] tau_out,
  output logic                      tau_valid_out,
  input  logic                      tau_ready_in,
  output logic [7:0]                window_idx_out,
  output logic                      overflow_out,
  output logic                      dropped_out,
  output logic                      busy_out
);

  localparam int TAU_W = $clog2(TAUMAX);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WIN_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam int GAP_W = $clog2(SAMPLE_GAP);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                  state_q, state_d;
  logic [GAP_W-1:0]        gap_cnt_q;
  logic [WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [WIN_W-1:0]        smp_cnt_q;
  logic [7:0]              win_idx_q;
  logic [WIDTH-1:0]        core_sample_q;
  logic [TAU_W-1:0]        tau_q;
  logic                    tau_vld_q;
  logic                    ovf_q;
  logic                    drop_q;

  logic fifo_full, fifo_nonempty, push, push_drop, issue, gap_done, drop_evt;

  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign push          = sample_valid_in && !fifo_full;
  assign push_drop     = sample_valid_in && fifo_full;
  assign gap_done      = (gap_cnt_q == GAP_W'(SAMPLE_GAP - 3));
  assign drop_evt      = core_result_valid_in && tau_vld_q && !tau_ready_in;

  // The head is popped and registered on the IDLE->ISSUE edge so that ISSUE
  // itself is the single cycle in which the core sees the strobe.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in && fifo_nonempty) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE:   state_d = GAP;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      smp_cnt_q     <= '0;
      win_idx_q     <= '0;
      core_sample_q <= '0;
      tau_q         <= '0;
      tau_vld_q     <= 1'b0;
      ovf_q         <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == ISSUE)    gap_cnt_q <= '0;
      else if (state_q == GAP) gap_cnt_q <= gap_cnt_q + GAP_W'(1);

      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);

      if (issue) begin
        rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
        core_sample_q <= mem_q[rd_ptr_q];
        if (smp_cnt_q == WIN_W'(WINDOW_SIZE - 1)) begin
          smp_cnt_q <= '0;
          win_idx_q <= win_idx_q + 8'd1;
        end else begin
          smp_cnt_q <= smp_cnt_q + WIN_W'(1);
        end
      end

      case ({push, issue})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // A fresh result always wins over acceptance, keeping valid asserted.
      if (core_result_valid_in) begin
        tau_q     <= core_taumin_in;
        tau_vld_q <= 1'b1;
      end else if (tau_vld_q && tau_ready_in) begin
        tau_vld_q <= 1'b0;
      end

      if (push_drop)        ovf_q <= 1'b1;
      else if (flag_clr_in) ovf_q <= 1'b0;

      if (drop_evt)         drop_q <= 1'b1;
      else if (flag_clr_in) drop_q <= 1'b0;
    end
  end

  assign core_sample_out = core_sample_q;
  assign core_valid_out  = (state_q == ISSUE);
  assign tau_out         = tau_q;
  assign tau_valid_out   = tau_vld_q;
  assign window_idx_out  = win_idx_q;
  assign overflow_out    = ovf_q;
  assign dropped_out     = drop_q;
  assign busy_out        = (state_q != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_yin_feed_ctrl.sv
// Directed bench for yin_feed_ctrl: issue spacing, FIFO overflow, window count,
// result handshake and reset behaviour, with hand-computed expectations.
module tb_yin_feed_ctrl;

  localparam int WIDTH       = 16;
  localparam int WINDOW_SIZE = 4;
  localparam int TAUMAX      = 2048;
  localparam int SAMPLE_GAP  = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TAU_W       = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             flag_clr;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic [WIDTH-1:0] core_sample;
  logic             core_valid;
  logic             res_valid;
  logic [TAU_W-1:0] taumin;
  logic [TAU_W-1:0] tau;
  logic             tau_valid;
  logic             tau_ready;
  logic [7:0]       window_idx;
  logic             overflow;
  logic             dropped;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int          pk[$];
  logic [15:0] pv[$];

  always #5 clk = ~clk;

  yin_feed_ctrl #(
    .WIDTH(WIDTH), .WINDOW_SIZE(WINDOW_SIZE), .TAUMAX(TAUMAX),
    .SAMPLE_GAP(SAMPLE_GAP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .flag_clr_in(flag_clr),
    .sample_in(sample), .sample_valid_in(sample_valid),
    .core_sample_out(core_sample), .core_valid_out(core_valid),
    .core_result_valid_in(res_valid), .core_taumin_in(taumin),
    .tau_out(tau), .tau_valid_out(tau_valid), .tau_ready_in(tau_ready),
    .window_idx_out(window_idx), .overflow_out(overflow),
    .dropped_out(dropped), .busy_out(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    pk.delete();
    pv.delete();
    for (int k = 1; k <= n; k++) begin
      tick();
      if (core_valid) begin
        pk.push_back(k);
        pv.push_back(core_sample);
      end
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_core_sample"}, 32'(core_sample), 32'h0);
    check({pfx, "_core_valid"},  32'(core_valid),  32'h0);
    check({pfx, "_tau"},         32'(tau),         32'h0);
    check({pfx, "_tau_valid"},   32'(tau_valid),   32'h0);
    check({pfx, "_window_idx"},  32'(window_idx),  32'h0);
    check({pfx, "_overflow"},    32'(overflow),    32'h0);
    check({pfx, "_dropped"},     32'(dropped),     32'h0);
    check({pfx, "_busy"},        32'(busy),        32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_k [3];
    logic [15:0] exp_v [3];
    exp_k = '{2, 10, 18};
    exp_v = '{16'h0011, 16'h0022, 16'h0033};

    rst = 1'b1; enable = 1'b0; flag_clr = 1'b0; sample = '0; sample_valid = 1'b0;
    res_valid = 1'b0; taumin = '0; tau_ready = 1'b0;

    // Reset with live inputs: they must be ignored.
    sample = 16'hBEEF; sample_valid = 1'b1; res_valid = 1'b1; taumin = 11'h7FF;
    repeat (3) tick();
    check_zero_outputs("rst");
    rst = 1'b0; sample_valid = 1'b0; res_valid = 1'b0;
    tick();
    check("rst_release_busy", 32'(busy), 32'h0);
    check("rst_release_valid", 32'(core_valid), 32'h0);

    // Three back-to-back pushes: issues at +2, +10, +18.
    pk.delete(); pv.delete();
    enable = 1'b1; sample = 16'h0011; sample_valid = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (core_valid) begin
        pk.push_back(k);
        pv.push_back(core_sample);
      end
      if (k == 3) check("hold_after_issue", 32'(core_sample), 32'h0011);
      case (k)
        1:       sample = 16'h0022;
        2:       sample = 16'h0033;
        3:       sample_valid = 1'b0;
        default: ;
      endcase
    end
    check("spacing_n_issue", 32'(pk.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("spacing_cycle%0d", i), (i < pk.size()) ? 32'(pk[i]) : 32'hFFFF_FFFF, 32'(exp_k[i]));
      check($sformatf("spacing_value%0d", i), (i < pv.size()) ? 32'(pv[i]) : 32'hFFFF_FFFF, 32'(exp_v[i]));
    end
    check("spacing_idle_busy", 32'(busy), 32'h0);

    // Window counter over 8 spaced samples.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sample = 16'h0100 + 16'(i); sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      repeat (9) tick();
      check($sformatf("win_idx_after_%0d", i + 1), 32'(window_idx), 32'((i + 1) / 4));
    end

    // Overflow with enable low.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample = 16'h00A0 + 16'(i); sample_valid = 1'b1;
      tick();
      if (i == 3) check("ovf_not_yet", 32'(overflow), 32'h0);
    end
    sample_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_busy", 32'(busy), 32'h1);
    flag_clr = 1'b1; sample = 16'h00EE; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("ovf_set_beats_clr", 32'(overflow), 32'h1);
    tick();
    flag_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);
    enable = 1'b1;
    capture(40);
    check("ovf_drain_count", 32'(pk.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_drain_value%0d", i), (i < pv.size()) ? 32'(pv[i]) : 32'hFFFF_FFFF, 32'h00A0 + 32'(i));
    check("ovf_drain_idle", 32'(busy), 32'h0);
    check("win_idx_after_12", 32'(window_idx), 32'd3);

    // Result handshake.
    tau_ready = 1'b0; res_valid = 1'b1; taumin = 11'h123;
    tick();
    res_valid = 1'b0;
    check("tau_first", 32'(tau), 32'h123);
    check("tau_first_valid", 32'(tau_valid), 32'h1);
    check("tau_first_dropped", 32'(dropped), 32'h0);
    res_valid = 1'b1; taumin = 11'h0AB;
    tick();
    res_valid = 1'b0;
    check("tau_overwrite", 32'(tau), 32'h0AB);
    check("tau_dropped", 32'(dropped), 32'h1);
    tick();
    check("tau_held_valid", 32'(tau_valid), 32'h1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("drop_cleared", 32'(dropped), 32'h0);
    res_valid = 1'b1; taumin = 11'h055; tau_ready = 1'b1;
    tick();
    res_valid = 1'b0; tau_ready = 1'b0;
    check("tau_accept_and_load", 32'(tau), 32'h055);
    check("tau_accept_valid", 32'(tau_valid), 32'h1);
    check("tau_accept_no_drop", 32'(dropped), 32'h0);
    tau_ready = 1'b1;
    tick();
    tau_ready = 1'b0;
    check("tau_consumed_valid", 32'(tau_valid), 32'h0);
    check("tau_consumed_hold", 32'(tau), 32'h055);
    res_valid = 1'b1; taumin = 11'h010;
    tick();
    check("tau_reload_no_drop", 32'(dropped), 32'h0);
    taumin = 11'h020; flag_clr = 1'b1;
    tick();
    res_valid = 1'b0; flag_clr = 1'b0;
    check("drop_set_beats_clr", 32'(dropped), 32'h1);

    // Reset in the middle of a gap with two samples still queued.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample = 16'h00B1 + 16'(i); sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    check("gap_busy", 32'(busy), 32'h1);
    check("gap_last_sample", 32'(core_sample), 32'h00B1);
    rst = 1'b1; sample_valid = 1'b1; sample = 16'h0DEA; res_valid = 1'b1; taumin = 11'h3FF;
    tick();
    tick();
    rst = 1'b0; sample_valid = 1'b0; res_valid = 1'b0;
    check_zero_outputs("gaprst");
    capture(12);
    check("gaprst_no_issue", 32'(pk.size()), 32'd0);
    pk.delete(); pv.delete();
    sample = 16'h00C5; sample_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      sample_valid = 1'b0;
      if (core_valid) begin
        pk.push_back(k);
        pv.push_back(core_sample);
      end
    end
    check("gaprst_new_cycle", (pk.size() > 0) ? 32'(pk[0]) : 32'hFFFF_FFFF, 32'd2);
    check("gaprst_new_value", (pv.size() > 0) ? 32'(pv[0]) : 32'hFFFF_FFFF, 32'h00C5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/yin_feed_ctrl.md
YIN_FEED_CTRL -- requirements
Module: yin_feed_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits.
REQ-002 Parameter WINDOW_SIZE, default 2048, samples per analysis window (power of two).
REQ-003 Parameter TAUMAX, default 2048, lag range of the pitch core.
REQ-004 Parameter SAMPLE_GAP, default 1040, minimum cycles between core sample pulses; SAMPLE_GAP >= 3.
REQ-005 Parameter FIFO_DEPTH, default 4, input buffer depth (power of two).
REQ-006 clk_in  input  1  single clock for all logic.
REQ-007 rst_in  input  1  reset, synchronous, active-high.
REQ-008 enable_in  input  1  permits issuing samples to the core.
REQ-009 flag_clr_in  input  1  clears sticky flags.
REQ-010 sample_in  input  WIDTH  incoming audio sample.
REQ-011 sample_valid_in  input  1  sample_in valid this cycle (single-cycle strobe).
REQ-012 core_sample_out  output  WIDTH  sample presented to the pitch core.
REQ-013 core_valid_out  output  1  one-cycle strobe qualifying core_sample_out.
REQ-014 core_result_valid_in  input  1  core result strobe.
REQ-015 core_taumin_in  input  $clog2(TAUMAX)  core lag result.
REQ-016 tau_out  output  $clog2(TAUMAX)  held lag result.
REQ-017 tau_valid_out  output  1  tau_out valid; held until accepted.
REQ-018 tau_ready_in  input  1  downstream accepts tau_out.
REQ-019 window_idx_out  output  8  completed-window count, wraps 255->0.
REQ-020 overflow_out  output  1  sticky: input sample dropped, FIFO full.
REQ-021 dropped_out  output  1  sticky: unaccepted result overwritten.
REQ-022 busy_out  output  1  state != IDLE or FIFO non-empty.

Function
REQ-023 FIFO push when sample_valid_in and not full; when full, sample discarded and overflow_out set next cycle.
REQ-024 FIFO push and pop in the same cycle are both performed; count unchanged.
REQ-025 FSM states IDLE, ISSUE, GAP.
REQ-026 IDLE -> ISSUE when enable_in=1 and FIFO non-empty (occupancy at cycle start); otherwise stay IDLE.
REQ-027 ISSUE: exactly one cycle; core_valid_out=1, core_sample_out = FIFO head, head popped; -> GAP.
REQ-028 GAP: lasts SAMPLE_GAP-2 cycles, then -> IDLE; enable_in ignored during GAP.
REQ-029 With a continuous backlog and enable_in=1, core_valid_out pulses exactly SAMPLE_GAP cycles apart; never closer.
REQ-030 core_sample_out holds its last value when core_valid_out=0.
REQ-031 Sample counter increments per ISSUE; at WINDOW_SIZE-1 it wraps to 0 and window_idx_out increments.
REQ-032 Sample latency: sample pushed into an empty FIFO while IDLE and enabled appears on core_valid_out 2 cycles later.
REQ-033 On core_result_valid_in: tau_out <= core_taumin_in and tau_valid_out <= 1 next cycle.
REQ-034 tau_valid_out=1 and tau_ready_in=1 with no new result: tau_valid_out <= 0.
REQ-035 New result in the same cycle as acceptance: new value loaded, tau_valid_out stays 1, dropped_out unchanged.
REQ-036 New result while tau_valid_out=1 and tau_ready_in=0: overwrite tau_out, set dropped_out.
REQ-037 flag_clr_in clears overflow_out and dropped_out; a same-cycle set event takes priority (flag ends 1).
REQ-038 enable_in deassert mid-operation: GAP completes, FSM parks in IDLE, FIFO keeps accepting.

Reset
REQ-039 rst_in=1: state IDLE, FIFO empty, sample counter 0; all outputs 0 (core_sample_out, core_valid_out, tau_out, tau_valid_out, window_idx_out, overflow_out, dropped_out, busy_out).
REQ-040 Reset during GAP aborts the gap; issue permitted from the first cycle after rst_in falls; spacing not enforced across reset.
REQ-041 Inputs ignored while rst_in=1, including sample_valid_in and core_result_valid_in.

Verification
REQ-042 SAMPLE_GAP=8, enable=1, push 3 samples 0x0011,0x0022,0x0033 back-to-back -> core_valid_out at cycles t+2, t+10, t+18 with those values in order.
REQ-043 FIFO_DEPTH=4, enable=0, push 5 samples -> first 4 retained, overflow_out=1, busy_out=1; flag_clr_in pulse -> overflow_out=0.
REQ-044 WINDOW_SIZE=4, feed 8 samples -> window_idx_out steps 0->1 after 4th issue, 1->2 after 8th.
REQ-045 core result 0x123 with tau_ready_in=0, then 0x0AB -> tau_out=0x0AB, dropped_out=1; result 0x055 in same cycle as ready -> tau_valid_out stays 1, dropped unchanged.
REQ-046 rst_in asserted mid-GAP with 2 samples queued -> all outputs 0, FIFO empty; first issue only after a new push.
